mixcolumns_seq: RTL and testbench

- Sequential, parametrised successor to the combinational MixColumns stage.
- Takes a 128-bit AES state over a valid/ready handshake and applies forward MixColumns or InvMixColumns, selected per block.
- Processes COLS_PER_CYCLE columns per clock, trading area against latency.
- Sits between the ShiftRows and AddRoundKey stages of the iterative encrypt/decrypt round datapath.

---
 rtl/aes_mc_pkg.sv | 50 +++++
 rtl/mixcolumn_fi.sv | 41 ++++
 rtl/mixcolumns_seq.sv | 116 +++++++++++
 tb/tb_mixcolumns_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_mc_pkg.sv
// ==========================================================================
// Module   : aes_mc_pkg
// Brief    : Shared FSM encoding and GF(2^8) constant multipliers for MixColumns
// Revision : 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

package aes_mc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } mc_state_e;

  // Low byte of the AES field polynomial x^8+x^4+x^3+x+1
  localparam logic [7:0] AES_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mixcolumn_fi.sv
// ==========================================================================
// Module   : mixcolumn_fi
// Brief    : Combinational single-column forward/inverse MixColumns unit
// Revision : 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module mixcolumn_fi
  import aes_mc_pkg::*;
(
  input  logic [31:0] i_col,
  input  logic        i_inv,
  output logic [31:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  always_comb begin
    o_col = '0;
    if (i_inv) begin
      o_col = {gm14(w_a0) ^ gm11(w_a1) ^ gm13(w_a2) ^ gm9(w_a3),
               gm9(w_a0)  ^ gm14(w_a1) ^ gm11(w_a2) ^ gm13(w_a3),
               gm13(w_a0) ^ gm9(w_a1)  ^ gm14(w_a2) ^ gm11(w_a3),
               gm11(w_a0) ^ gm13(w_a1) ^ gm9(w_a2)  ^ gm14(w_a3)};
    end else begin
      o_col = {gm2(w_a0) ^ gm3(w_a1) ^ w_a2      ^ w_a3,
               w_a0      ^ gm2(w_a1) ^ gm3(w_a2) ^ w_a3,
               w_a0      ^ w_a1      ^ gm2(w_a2) ^ gm3(w_a3),
               gm3(w_a0) ^ w_a1      ^ w_a2      ^ gm2(w_a3)};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mixcolumns_seq.sv
// ==========================================================================
// Module   : mixcolumns_seq
// Brief    : Sequential MixColumns/InvMixColumns, COLS_PER_CYCLE columns/clock
// Revision : 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module mixcolumns_seq
  import aes_mc_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_state_in,
  input  logic         i_inv_mode,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_state_out,
  output logic         o_busy
);

  localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;
  localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int SLICE_W   = 32 * COLS_PER_CYCLE;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mixcolumns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e           r_state, w_state_nxt;
  logic [STEP_W-1:0]   r_step;
  logic [127:0]        r_work;
  logic [127:0]        r_out;
  logic                r_mode;

  logic [6:0]          w_msb;
  logic [SLICE_W-1:0]  w_slice_in;
  logic [SLICE_W-1:0]  w_slice_out;
  logic [127:0]        w_work_nxt;

  // Column 0 lives at the MSB end, so column step*C starts at bit 127-32*step*C
  assign w_msb      = 7'(127 - SLICE_W * int'(r_step));
  assign w_slice_in = r_work[w_msb -: SLICE_W];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    mixcolumn_fi u_col (
      .i_col (w_slice_in[g*32 +: 32]),
      .i_inv (r_mode),
      .o_col (w_slice_out[g*32 +: 32])
    );
  end

  always_comb begin
    w_work_nxt = r_work;
    w_work_nxt[w_msb -: SLICE_W] = w_slice_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (i_in_valid)          w_state_nxt = COMPUTE;
      COMPUTE: if (r_step == LAST_STEP) w_state_nxt = DONE;
      DONE:    if (i_out_ready)         w_state_nxt = IDLE;
      default:                          w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_out  <= '0;
      r_mode <= 1'b0;
      r_step <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_work <= i_state_in;
            r_mode <= i_inv_mode;
            r_step <= '0;
          end
        end
        COMPUTE: begin
          r_work <= w_work_nxt;
          if (r_step == LAST_STEP) begin
            r_out <= w_work_nxt;
          end else begin
            r_step <= r_step + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = (r_state == DONE);
  assign o_busy      = (r_state != IDLE);
  assign o_state_out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_mixcolumns_seq.sv
// ==========================================================================
// Module   : tb_mixcolumns_seq
// Brief    : Scoreboard bench driving one DUT per legal COLS_PER_CYCLE (1,2,4)
// Revision : 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mixcolumns_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         inv_mode  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic         busy      [3];
  logic [127:0] state_in  [3];
  logic [127:0] state_out [3];

  logic [127:0] exp_q [3][$];
  int n_checks = 0;
  int n_errors = 0;
  int rand_done = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Reference model: generic shift-and-add field multiply and the textbook matrices
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
    logic [127:0] r = '0;
    int cf [4];
    logic [7:0] acc;
    logic [7:0] a;
    if (inv) begin
      cf[0] = 14; cf[1] = 11; cf[2] = 13; cf[3] = 9;
    end else begin
      cf[0] = 2;  cf[1] = 3;  cf[2] = 1;  cf[3] = 1;
    end
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          a = s[127 - 32*c - 8*j -: 8];
          acc ^= gmul(a, 8'(cf[(j - rr + 4) % 4]));
        end
        r[127 - 32*c - 8*rr -: 8] = acc;
      end
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mixcolumns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (in_valid[g]),
      .o_in_ready  (in_ready[g]),
      .i_state_in  (state_in[g]),
      .i_inv_mode  (inv_mode[g]),
      .o_out_valid (out_valid[g]),
      .i_out_ready (out_ready[g]),
      .o_state_out (state_out[g]),
      .o_busy      (busy[g])
    );

    // Monitor: a handshake completes on the following rising edge
    always @(negedge clk) begin
      logic [127:0] e;
      if (rst_n && out_valid[g] && out_ready[g]) begin
        if (exp_q[g].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out c%0d: actual %h required no output", 1 << g, state_out[g]);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("result_c%0d", 1 << g), state_out[g], e);
        end
      end
    end
  end

  task automatic send(input int idx, input logic [127:0] s, input logic inv,
                      input logic [127:0] exp, input bit chk_lat, input bit toggle);
    int w;
    int lat;
    @(posedge clk); #1;
    in_valid[idx] = 1'b1;
    state_in[idx] = s;
    inv_mode[idx] = inv;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!in_ready[idx] && w < 500);
    if (!in_ready[idx]) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout c%0d: actual in_ready 0 required 1", 1 << idx);
      in_valid[idx] = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q[idx].push_back(exp);
    #1;
    in_valid[idx] = 1'b0;
    if (toggle) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        inv_mode[idx] = ~inv_mode[idx];
      end
    end
    if (chk_lat) begin
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!out_valid[idx] && lat < 50);
      check($sformatf("latency_c%0d", 1 << idx), 128'(lat), 128'(4 >> idx));
    end
  endtask

  task automatic run_random(input int idx);
    logic [127:0] x;
    logic [127:0] y;
    for (int n = 0; n < 1000; n++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = mix_ref(x, 1'b0);
      send(idx, x, 1'b0, y, 1'b0, 1'b0);
      send(idx, y, 1'b1, x, 1'b0, 1'b0);
    end
    rand_done++;
  endtask

  task automatic bp_driver();
    int cyc = 0;
    while (rand_done < 3 && cyc < 80000) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    for (int i = 0; i < 3; i++) out_ready[i] = 1'b1;
  endtask

  initial begin
    logic [127:0] x;
    logic [127:0] snap;
    int w;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      inv_mode[i]  = 1'b0;
      out_ready[i] = 1'b1;
      state_in[i]  = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_in_ready_c%0d", 1 << i), 128'(in_ready[i]), 128'(1));
      check($sformatf("rst_out_valid_c%0d", 1 << i), 128'(out_valid[i]), 128'(0));
      check($sformatf("rst_state_out_c%0d", 1 << i), state_out[i], 128'(0));
      check($sformatf("rst_busy_c%0d", 1 << i), 128'(busy[i]), 128'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Known-answer vectors
    send(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
         128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 1'b0);
    send(2, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1,
         128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 1'b1, 1'b0);

    // Backpressure on C=2 with a stray input pulse while holding the result
    out_ready[1] = 1'b0;
    x = {$urandom, $urandom, $urandom, $urandom};
    send(1, x, 1'b0, mix_ref(x, 1'b0), 1'b1, 1'b0);
    snap = state_out[1];
    check("bp_first_result", snap, mix_ref(x, 1'b0));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_hold_stable", state_out[1], snap);
      check("bp_in_ready_low", 128'(in_ready[1]), 128'(0));
      check("bp_out_valid_high", 128'(out_valid[1]), 128'(1));
      if (k == 2) begin
        in_valid[1] = 1'b1;
        state_in[1] = ~x;
      end
      if (k == 4) in_valid[1] = 1'b0;
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp_in_ready_after", 128'(in_ready[1]), 128'(1));
    check("bp_out_valid_after", 128'(out_valid[1]), 128'(0));
    repeat (6) @(posedge clk);

    // Mode isolation: inverse block with inv_mode toggling, then a forward block
    x = {$urandom, $urandom, $urandom, $urandom};
    send(0, x, 1'b1, mix_ref(x, 1'b1), 1'b0, 1'b1);
    x = {$urandom, $urandom, $urandom, $urandom};
    send(0, x, 1'b0, mix_ref(x, 1'b0), 1'b0, 1'b0);
    w = 0;
    while (exp_q[0].size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end

    // Reset in the middle of COMPUTE on C=1
    x = {$urandom, $urandom, $urandom, $urandom};
    send(0, x, 1'b0, mix_ref(x, 1'b0), 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid[0]), 128'(0));
    check("midrst_state_out", state_out[0], 128'(0));
    check("midrst_in_ready", 128'(in_ready[0]), 128'(1));
    check("midrst_busy", 128'(busy[0]), 128'(0));
    exp_q[0].delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    x = {$urandom, $urandom, $urandom, $urandom};
    send(0, x, 1'b1, mix_ref(x, 1'b1), 1'b1, 1'b0);

    // Random round trips on all three widths concurrently
    fork
      run_random(0);
      run_random(1);
      run_random(2);
      bp_driver();
    join

    w = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_c%0d", 1 << i), 128'(exp_q[i].size()), 128'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
